seq_divider: RTL and testbench

//   Iterative unsigned integer divider: y_q = a / b, y_r = a % b, both W bits.

---
 rtl/seq_divider.sv | 135 +++++++++++++
 tb/tb_seq_divider.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider: y_q = a / b, y_r = a % b, one quotient bit per clock.
// Ports: clk, rst_n (async active-low); start/a/b request; busy/done status;
//        y_q/y_r/div_by_zero results, held until the next completion.
module seq_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] y_q,
  output logic [W-1:0] y_r,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   rem_q, rem_d;     // partial remainder, always < divisor
  logic [W-1:0]   dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
  logic [W-1:0]   dsr_q, dsr_d;     // latched divisor
  logic           zero_q, zero_d;   // latched divisor was zero
  logic           busy_q, busy_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   rmd_q, rmd_d;
  logic           dbz_q, dbz_d;

  // One restoring step: shifted partial remainder is W+1 bits wide, so the
  // trial compare never overflows; the subtraction result fits in W bits
  // whenever it is kept because it is then below the divisor.
  logic [W:0]     shifted;
  logic           trial_ok;
  logic [W-1:0]   trial;

  assign shifted  = {rem_q, dvd_q[W-1]};
  assign trial_ok = (shifted >= {1'b0, dsr_q});
  assign trial    = shifted[W-1:0] - dsr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    zero_d  = zero_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dsr_d   = b;
          zero_d  = (b == '0);
          dvd_d   = a;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (zero_q) begin
          // Zero divisor: no iteration, report saturated quotient.
          quo_d   = '1;
          rmd_d   = dvd_q;
          dbz_d   = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CW'(W)) begin
          // All W quotient bits are in; this edge publishes them.
          quo_d   = dvd_q;
          rmd_d   = rem_q;
          dbz_d   = 1'b0;
          state_d = DONE;
        end else begin
          rem_d = trial_ok ? trial : shifted[W-1:0];
          dvd_d = {dvd_q[W-2:0], trial_ok};
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // busy covers only the iterating cycles: not the load cycle after
    // acceptance and not the publishing edge.
    busy_d = (state_q == RUN) && (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = (state_q == DONE);
  assign y_q         = quo_q;
  assign y_r         = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases with literal results, then random traffic
// checked every cycle against an arithmetic model of accept/latency/result rules.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] y_q;
  logic [W-1:0] y_r;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .y_q         (y_q),
    .y_r         (y_r),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An accepted request at edge acc finishes L edges later (W+1, or 1 for b==0);
  // the edge after that ends the done cycle and cannot accept.
  int           ecnt = 0;
  bit           active = 0;
  int           acc = 0;
  int           lat = 0;
  logic [W-1:0] pq, pr;
  logic         pdbz;
  logic [W-1:0] eyq = '0, eyr = '0;
  logic         edbz = 1'b0;

  always @(posedge clk) begin
    ecnt++;
    if (!rst_n) begin
      active = 0;
      eyq    = '0;
      eyr    = '0;
      edbz   = 1'b0;
    end else begin
      if (active && ecnt == acc + lat) begin
        eyq  = pq;
        eyr  = pr;
        edbz = pdbz;
      end
      if (active && ecnt > acc + lat) begin
        active = 0;
      end else if (!active && start) begin
        active = 1;
        acc    = ecnt;
        if (b == '0) begin
          pq = '1; pr = a; pdbz = 1'b1; lat = 1;
        end else begin
          pq = a / b; pr = a % b; pdbz = 1'b0; lat = W + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic exp_busy, exp_done;
    exp_busy = active && !pdbz && (ecnt >= acc + 1) && (ecnt <= acc + W);
    exp_done = active && (ecnt == acc + lat);
    chk("busy", busy, exp_busy);
    chk("done", done, exp_done);
    chk("y_q", y_q, eyq);
    chk("y_r", y_r, eyr);
    chk("div_by_zero", div_by_zero, edbz);
  end

  // ---------------- directed driver ----------------
  task automatic run_div(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] lq, input logic [W-1:0] lr,
                         input logic ldbz, input bit hold);
    int  bcnt;
    bit  got;
    int  exp_lat;
    exp_lat = (ib == '0) ? 1 : W + 1;
    @(negedge clk);
    start = 1'b1; a = ia; b = ib;
    @(negedge clk);
    if (!hold) start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    bcnt = 0;
    got  = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (k == 10) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        got = 1;
        chk("latency", k, exp_lat);
        chk("lit_y_q", y_q, lq);
        chk("lit_y_r", y_r, lr);
        chk("lit_dbz", div_by_zero, ldbz);
        chk("model_y_q", eyq, lq);
        chk("model_y_r", eyr, lr);
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    chk("busy_cycles", bcnt, (ib == '0) ? 0 : W);
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_y_q", y_q, 0);
    chk("rst_y_r", y_r, 0);
    chk("rst_dbz", div_by_zero, 0);
    #2 rst_n = 1'b1;

    run_div(16'h0000, 16'hAAFF, 16'h0000, 16'h0000, 1'b0, 0);
    run_div(16'h01E4, 16'h0016, 16'h0016, 16'h0000, 1'b0, 0);
    run_div(16'hFF23, 16'h0001, 16'hFF23, 16'h0000, 1'b0, 0);
    run_div(16'hFFFF, 16'h0007, 16'h2492, 16'h0001, 1'b0, 0);
    run_div(16'd100,  16'h0000, 16'hFFFF, 16'd100,  1'b1, 0);
    run_div(16'd5000, 16'd33,   16'd151,  16'd17,   1'b0, 1);

    // Reset in the middle of a division.
    @(negedge clk);
    start = 1'b1; a = 16'd40000; b = 16'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_y_q", y_q, 0);
    chk("midrst_y_r", y_r, 0);
    chk("midrst_dbz", div_by_zero, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_div(16'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 0);

    // Random traffic, including start pulses while busy and during done.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       a = '0;
        1:       a = '1;
        default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = 16'd1;
        2:       b = W'($urandom_range(2, 15));
        3:       b = '1;
        default: b = W'($urandom);
      endcase
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
